// File: rtl/vnlp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : vnlp_accumulator
//  Purpose  : Per-node X^2+Y^2 via a sequential shift-add multiplier, with
//             saturating sums of X, Y, X^2+Y^2 and a node count. Raises a
//             sticky done flag after the node flagged last.
//  Revision : 1.0  initial release
// ============================================================================
module vnlp_accumulator #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,       // asynchronous, active-low
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic              in_last,
   output logic [ACC_W-1:0]  sum_x,
   output logic [ACC_W-1:0]  sum_y,
   output logic [ACC_W-1:0]  sum_sq,
   output logic [CNT_W-1:0]  count,
   output logic              out_valid,
   output logic              overflow
);

   localparam int PROD_W = 2*DATA_W + 1;          // holds X^2+Y^2 exactly
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_MULX = 3'd2,
      S_MULY = 3'd3,
      S_ACC  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t              state_q,  state_d;
   logic [DATA_W-1:0]   x_q,      x_d;
   logic [DATA_W-1:0]   y_q,      y_d;
   logic                last_q,   last_d;
   logic [PROD_W-1:0]   prod_q,   prod_d;
   logic [PROD_W-1:0]   mcand_q,  mcand_d;   // multiplicand, shifts left
   logic [DATA_W-1:0]   mplier_q, mplier_d;  // multiplier, scanned LSB-first
   logic [BIT_W-1:0]    bit_q,    bit_d;
   logic [ACC_W-1:0]    sx_q,     sx_d;
   logic [ACC_W-1:0]    sy_q,     sy_d;
   logic [ACC_W-1:0]    sq_q,     sq_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic                ovf_q,    ovf_d;

   // Widened sums: the extra top bit is the saturation indicator
   logic [ACC_W:0]      w_sx_sum;
   logic [ACC_W:0]      w_sy_sum;
   logic [ACC_W:0]      w_sq_sum;
   logic [CNT_W:0]      w_cnt_sum;

   assign w_sx_sum  = {1'b0, sx_q}  + {{(ACC_W+1-DATA_W){1'b0}}, x_q};
   assign w_sy_sum  = {1'b0, sy_q}  + {{(ACC_W+1-DATA_W){1'b0}}, y_q};
   assign w_sq_sum  = {1'b0, sq_q}  + {{(ACC_W+1-PROD_W){1'b0}}, prod_q};
   assign w_cnt_sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

   // Handshake depends only on state and start, never on in_valid
   assign in_ready  = (state_q == S_WAIT) && !start;
   assign out_valid = (state_q == S_DONE);
   assign sum_x     = sx_q;
   assign sum_y     = sy_q;
   assign sum_sq    = sq_q;
   assign count     = cnt_q;
   assign overflow  = ovf_q;

   // Next-state and datapath: capture, shift-add multiply, saturating accumulate
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      last_d   = last_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      bit_d    = bit_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      sq_d     = sq_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: ;
         S_WAIT: begin
            if (in_valid) begin
               x_d      = in_x;
               y_d      = in_y;
               last_d   = in_last;
               prod_d   = '0;
               mcand_d  = {{(PROD_W-DATA_W){1'b0}}, in_x};
               mplier_d = in_x;
               bit_d    = '0;
               state_d  = S_MULX;
            end
         end
         S_MULX, S_MULY: begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bit_d    = bit_q + C_BIT_ONE;
            if (bit_q == C_LAST_BIT) begin
               bit_d = '0;
               if (state_q == S_MULX) begin
                  // Second pass squares y into the same product register
                  mcand_d  = {{(PROD_W-DATA_W){1'b0}}, y_q};
                  mplier_d = y_q;
                  state_d  = S_MULY;
               end else begin
                  state_d  = S_ACC;
               end
            end
         end
         S_ACC: begin
            if (w_sx_sum[ACC_W]) begin
               sx_d = '1; ovf_d = 1'b1;
            end else begin
               sx_d = w_sx_sum[ACC_W-1:0];
            end
            if (w_sy_sum[ACC_W]) begin
               sy_d = '1; ovf_d = 1'b1;
            end else begin
               sy_d = w_sy_sum[ACC_W-1:0];
            end
            if (w_sq_sum[ACC_W]) begin
               sq_d = '1; ovf_d = 1'b1;
            end else begin
               sq_d = w_sq_sum[ACC_W-1:0];
            end
            if (w_cnt_sum[CNT_W]) begin
               cnt_d = '1; ovf_d = 1'b1;
            end else begin
               cnt_d = w_cnt_sum[CNT_W-1:0];
            end
            state_d = last_q ? S_DONE : S_WAIT;
         end
         S_DONE: ;
         default: state_d = S_IDLE;
      endcase

      // start wins over everything, abandoning any multiply in flight
      if (start) begin
         sx_d    = '0;
         sy_d    = '0;
         sq_d    = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         state_d = S_WAIT;
      end
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         last_q   <= 1'b0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         bit_q    <= '0;
         sx_q     <= '0;
         sy_q     <= '0;
         sq_q     <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         last_q   <= last_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         bit_q    <= bit_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         sq_q     <= sq_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/vnlp_accumulator.md
# vnlp_accumulator

Downstream consumer of the VNLP list-walk control path: for every node (X, Y) fetched during a traversal it computes X² + Y² with a sequential shift-add multiplier. It accumulates ΣX, ΣY, Σ(X²+Y²) and a node count. It raises a sticky done flag after the node marked last. The list-walk stage presents one node per handshake; this block back-pressures it while the multiply runs.

## Interface
- DATA_W, default 8: unsigned width of X and Y.
- ACC_W, default 24: width of all three accumulators; must be ≥ 2*DATA_W+1.
- CNT_W, default 8: width of the node counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears all results and arms the block.
- in_valid  in  1  node X/Y/last are valid.
- in_ready  out  1  block can accept a node this cycle.
- in_x  in  DATA_W  node X coordinate, unsigned.
- in_y  in  DATA_W  node Y coordinate, unsigned.
- in_last  in  1  this node is the final node of the list.
- sum_x  out  ACC_W  ΣX.
- sum_y  out  ACC_W  ΣY.
- sum_sq  out  ACC_W  Σ(X²+Y²).
- count  out  CNT_W  number of nodes accumulated.
- out_valid  out  1  results final; held until the next start.
- overflow  out  1  sticky; some accumulator or the counter saturated.

## Operation
- States:
  - S_idle: after reset, in_ready=0. Goes to S_wait on start.
  - S_wait: in_ready=1. On in_valid&in_ready, captures x, y and last, clears the product register, and goes to S_mulx.
  - S_mulx: DATA_W cycles of shift-add computing x*x (LSB-first multiplier scan).
  - S_muly: DATA_W cycles computing y*y, added into the same product register.
  - S_acc: one cycle.
    - Adds x to sum_x, y to sum_y and the product to sum_sq; increments count.
    - Goes to S_done if the captured last=1, else to S_wait.
  - S_done: out_valid=1 and in_ready=0. Waits for start.
- start has priority in every state:
  - Clears sum_x, sum_y, sum_sq, count, overflow and out_valid; goes to S_wait on the next edge.
  - A multiply in progress is abandoned.
  - in_ready is forced to 0 combinationally while start=1, so no node is accepted in the start cycle.
- Arithmetic:
  - The product register is 2*DATA_W+1 bits, so X²+Y² is exact.
  - Every accumulator add and the count increment saturate at all-ones.
  - Any saturation sets overflow, which stays set until start or reset.
- in_x, in_y and in_last are sampled only on the acceptance edge. Changes after that edge are ignored.
- Reset, at any time including mid-multiply:
  - State goes to S_idle.
  - Outputs are 0: in_ready, sum_x, sum_y, sum_sq, count, out_valid and overflow.
  - Internal capture and product registers are cleared.

## Timing
- Acceptance edge E0 is the edge where state moves S_wait→S_mulx.
- S_mulx covers E0..E8, S_muly covers E8..E16 and S_acc covers E16..E17 (for DATA_W=8; in general 2*DATA_W+1 cycles).
- Results update at E17, and in_ready or out_valid is visible from E17.
- Throughput: one node per 2*DATA_W+2 cycles when in_valid is held high.
- in_valid may be asserted without in_ready; upstream must hold the data until the handshake.
- in_ready depends only on the state and on start, never on in_valid.
- out_valid goes high on the same edge as the final accumulator update. It never toggles before that edge.
- in_last on the first node gives count=1 and done after 17 cycles.
- in_valid while in S_idle or S_done is ignored; in_ready is 0 there.

## Test plan
- Reset then check idle:
  - Stimulus: rst low mid-sim, then release; start never pulsed.
  - Required: all outputs 0, in_ready=0, in_valid ignored indefinitely.
- Two-node list:
  - Stimulus: start; nodes (3,4) then (1,2,last).
  - Required: sum_x=4, sum_y=6, sum_sq=30, count=2, overflow=0.
  - Required: out_valid rises exactly 17 cycles after the second acceptance edge; in_ready low for 17 cycles after each acceptance.
- Saturation with ACC_W=17:
  - Stimulus: nodes (255,255), (255,255,last).
  - Required: after the first node, sum_sq=130050 and overflow=0.
  - Required: after the second, sum_sq=131071 and overflow=1; sum_x=510, count=2.
- Abort:
  - Stimulus: start pulse during S_muly of the second node of a list; then one node (2,2,last).
  - Required: the aborted node never contributes; final sum_sq=8, count=1.
- Start and valid in the same cycle:
  - Stimulus: start=1 and in_valid=1 together, with in_x=9, held one cycle.
  - Required: node not accepted; it is accepted on the following cycle; count increments once.
- Reset mid-multiply:
  - Stimulus: rst low during S_mulx.
  - Required: outputs clear asynchronously without waiting for a clock edge; after release the block is in S_idle with in_ready=0.
